// File: rtl/traffic_monitor.sv
// Passive checker for the traffic_control light buses: flags bad encodings, green
// conflicts, illegal phase steps, countdown breaks and stuck phases; keeps sticky flags.
module traffic_monitor #(
    parameter int unsigned MAX_DWELL = 63
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [2:0] A_lights,
    input  logic [2:0] B_lights,
    input  logic [3:0] num_out,
    input  logic [2:0] cases,
    input  logic       clr,
    output logic [4:0] err_pulse,
    output logic [4:0] err_sticky,
    output logic       err_any,
    output logic [7:0] err_cnt
);

    localparam logic [2:0] LT_GREEN  = 3'b001;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_RED    = 3'b100;

    function automatic logic is_onehot(input logic [2:0] l);
        return (l == LT_GREEN) || (l == LT_YELLOW) || (l == LT_RED);
    endfunction

    function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
        return ((prev == LT_GREEN)  && (cur == LT_YELLOW)) ||
               ((prev == LT_YELLOW) && (cur == LT_RED))    ||
               ((prev == LT_RED)    && (cur == LT_GREEN));
    endfunction

    logic [2:0] pA_q, pA_d;
    logic [2:0] pB_q, pB_d;
    logic [3:0] pnum_q, pnum_d;
    logic [2:0] pcases_q, pcases_d;
    logic       valid_q, valid_d;
    logic [7:0] dwell_q, dwell_d;
    logic [4:0] pulse_q, pulse_d;
    logic [4:0] sticky_q, sticky_d;
    logic [7:0] cnt_q, cnt_d;

    logic okA, okB, chA, chB, gate;
    logic e_enc, e_conf, e_seq, e_cnt, e_stall;

    always_comb begin
        okA  = is_onehot(A_lights);
        okB  = is_onehot(B_lights);
        chA  = (A_lights != pA_q);
        chB  = (B_lights != pB_q);
        // Sequence and countdown rules only apply in steady normal mode with history.
        gate = valid_q && (cases == 3'd0) && (pcases_q == 3'd0);

        e_enc  = !okA || !okB;
        e_conf = okA && okB && !A_lights[2] && !B_lights[2];
        e_seq  = gate && ((chA && !legal_step(pA_q, A_lights)) ||
                          (chB && !legal_step(pB_q, B_lights)));
        if (chA || chB) begin
            e_cnt = gate && (pnum_q != 4'd0);
        end else begin
            e_cnt = gate && ((pnum_q == 4'd0) || (num_out != pnum_q - 4'd1));
        end

        if (!valid_q || chA || chB) begin
            dwell_d = 8'd0;
        end else if (dwell_q == 8'hFF) begin
            dwell_d = dwell_q;
        end else begin
            dwell_d = dwell_q + 8'd1;
        end
        e_stall = ({24'd0, dwell_d} > MAX_DWELL);

        pulse_d = {e_stall, e_cnt, e_seq, e_conf, e_enc};

        // A clear wins over this sample's accumulation; the pulse is still reported.
        if (clr) begin
            sticky_d = 5'd0;
            cnt_d    = 8'd0;
        end else begin
            sticky_d = sticky_q | pulse_d;
            cnt_d    = ((|pulse_d) && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
        end

        pA_d     = A_lights;
        pB_d     = B_lights;
        pnum_d   = num_out;
        pcases_d = cases;
        valid_d  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            pA_q     <= 3'd0;
            pB_q     <= 3'd0;
            pnum_q   <= 4'd0;
            pcases_q <= 3'd0;
            valid_q  <= 1'b0;
            dwell_q  <= 8'd0;
            pulse_q  <= 5'd0;
            sticky_q <= 5'd0;
            cnt_q    <= 8'd0;
        end else begin
            pA_q     <= pA_d;
            pB_q     <= pB_d;
            pnum_q   <= pnum_d;
            pcases_q <= pcases_d;
            valid_q  <= valid_d;
            dwell_q  <= dwell_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign err_pulse  = pulse_q;
    assign err_sticky = sticky_q;
    assign err_any    = |sticky_q;
    assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: each step drives one sample, then checks the
// registered result one edge later against hand-computed values.
module tb_traffic_monitor;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    localparam logic [2:0] PA [4] = '{G, Y, R, R};
    localparam logic [2:0] PB [4] = '{R, R, G, Y};
    localparam int         RL [4] = '{9, 2, 9, 2};

    logic       clk = 1'b0;
    logic       rst_a;
    logic [2:0] A_lights, B_lights, cases;
    logic [3:0] num_out;
    logic       clr;
    logic [4:0] err_pulse, err_sticky;
    logic       err_any;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    traffic_monitor #(.MAX_DWELL(63)) dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .A_lights   (A_lights),
        .B_lights   (B_lights),
        .num_out    (num_out),
        .cases      (cases),
        .clr        (clr),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_any    (err_any),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [2:0] a, input logic [2:0] b, input logic [3:0] n,
                        input logic [2:0] cs, input logic c);
        A_lights = a;
        B_lights = b;
        num_out  = n;
        cases    = cs;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] p, input logic [4:0] s,
                           input logic a, input logic [7:0] c);
        chk({tag, "_pulse"},  {3'd0, err_pulse},  {3'd0, p});
        chk({tag, "_sticky"}, {3'd0, err_sticky}, {3'd0, s});
        chk({tag, "_any"},    {7'd0, err_any},    {7'd0, a});
        chk({tag, "_cnt"},    err_cnt,            c);
    endtask

    initial begin
        int stalls;

        // Reset held for two edges
        rst_a = 1'b1;
        step(G, R, 4'd9, 3'd0, 1'b0);
        step(G, R, 4'd9, 3'd0, 1'b0);
        chk_all("reset", 5'd0, 5'd0, 1'b0, 8'd0);
        rst_a = 1'b0;

        // Legal cycling: four full rounds of G/R, Y/R, R/G, R/Y
        for (int c = 0; c < 4; c++) begin
            for (int p = 0; p < 4; p++) begin
                for (int n = RL[p]; n >= 0; n--) begin
                    step(PA[p], PB[p], 4'(n), 3'd0, 1'b0);
                    chk("legal_pulse", {3'd0, err_pulse}, 8'd0);
                end
            end
        end
        chk_all("legal_end", 5'd0, 5'd0, 1'b0, 8'd0);

        // Both red (legal), then both green: conflict only
        step(R, R, 4'd0, 3'd0, 1'b0);
        chk("allred_pulse", {3'd0, err_pulse}, 8'd0);
        step(G, G, 4'd5, 3'd0, 1'b0);
        chk_all("conflict", 5'b00010, 5'b00010, 1'b1, 8'd1);

        // A=011: encoding error; also illegal step with a nonzero countdown
        step(3'b011, G, 4'd5, 3'd0, 1'b0);
        chk("enc_bit", {7'd0, err_pulse[0]}, 8'd1);
        chk_all("enc", 5'b01101, 5'b01111, 1'b1, 8'd2);

        // Mode change resynchronises history without SEQ/CNT
        step(G, R, 4'd4, 3'd1, 1'b0);
        chk("resync1", {3'd0, err_pulse}, 8'd0);
        step(G, R, 4'd4, 3'd0, 1'b0);
        chk("resync2", {3'd0, err_pulse}, 8'd0);

        // G->R with pnum=4: SEQ and CNT together, one count
        step(R, R, 4'd9, 3'd0, 1'b0);
        chk_all("seqcnt", 5'b01100, 5'b01111, 1'b1, 8'd3);
        step(R, R, 4'd8, 3'd0, 1'b0);
        chk("count8", {3'd0, err_pulse}, 8'd0);
        step(R, R, 4'd7, 3'd0, 1'b0);
        chk("count7", {3'd0, err_pulse}, 8'd0);
        step(R, R, 4'd5, 3'd0, 1'b0);
        chk_all("cntskip", 5'b01000, 5'b01111, 1'b1, 8'd4);

        // Override window
        step(G, R, 4'd3,  3'd1, 1'b0);
        chk("ovr1", {3'd0, err_pulse}, 8'd0);
        step(R, R, 4'd12, 3'd1, 1'b0);
        chk("ovr_g2r", {3'd0, err_pulse}, 8'd0);
        step(G, G, 4'd0,  3'd1, 1'b0);
        chk_all("ovr_conflict", 5'b00010, 5'b01111, 1'b1, 8'd5);
        step(R, R, 4'd7,  3'd1, 1'b0);
        chk("ovr4", {3'd0, err_pulse}, 8'd0);
        step(R, R, 4'd1,  3'd1, 1'b0);
        chk("ovr5", {3'd0, err_pulse}, 8'd0);
        step(R, R, 4'd15, 3'd1, 1'b0);
        chk("ovr6", {3'd0, err_pulse}, 8'd0);
        step(R, R, 4'd2,  3'd1, 1'b0);
        chk("ovr7", {3'd0, err_pulse}, 8'd0);
        step(R, R, 4'd9,  3'd1, 1'b0);
        chk("ovr8", {3'd0, err_pulse}, 8'd0);
        step(R, R, 4'd3,  3'd1, 1'b0);
        chk("ovr9", {3'd0, err_pulse}, 8'd0);
        step(R, R, 4'd3,  3'd1, 1'b0);
        chk("ovr10", {3'd0, err_pulse}, 8'd0);
        step(R, R, 4'd8,  3'd0, 1'b0);
        chk("ovr_return", {3'd0, err_pulse}, 8'd0);
        step(R, R, 4'd7,  3'd0, 1'b0);
        chk("ovr_after", {3'd0, err_pulse}, 8'd0);
        step(R, R, 4'd7,  3'd0, 1'b0);
        chk_all("ovr_cnt_back", 5'b01000, 5'b01111, 1'b1, 8'd6);

        // Stall: change once, then 69 unchanged samples (override keeps SEQ/CNT quiet)
        stalls = 0;
        step(G, R, 4'd0, 3'd1, 1'b0);
        chk("stall_start", {3'd0, err_pulse}, 8'd0);
        for (int k = 1; k <= 69; k++) begin
            step(G, R, 4'd0, 3'd1, 1'b0);
            if (err_pulse[4]) stalls++;
            chk("stall_step", {3'd0, err_pulse}, (k >= 64) ? 8'h10 : 8'h00);
        end
        chk("stall_total", 8'(stalls), 8'd6);
        chk("stall_cnt", err_cnt, 8'd12);
        step(Y, R, 4'd0, 3'd1, 1'b0);
        chk("stall_stop1", {3'd0, err_pulse}, 8'd0);
        step(Y, R, 4'd0, 3'd1, 1'b0);
        chk("stall_stop2", {3'd0, err_pulse}, 8'd0);

        // Saturation: 300 conflicting samples
        for (int k = 0; k < 300; k++) begin
            step(G, G, 4'd0, 3'd1, 1'b0);
        end
        chk("sat_cnt", err_cnt, 8'd255);
        chk("sat_pulse", {3'd0, err_pulse}, 8'h12);

        // Clear during an erroneous sample
        step(G, G, 4'd0, 3'd1, 1'b1);
        chk_all("clr", 5'b10010, 5'd0, 1'b0, 8'd0);
        step(G, G, 4'd0, 3'd1, 1'b0);
        chk_all("after_clr", 5'b10010, 5'b10010, 1'b1, 8'd1);

        // Reset mid-phase, then the first sample must not see stale history
        rst_a = 1'b1;
        step(R, R, 4'd3, 3'd0, 1'b0);
        chk_all("midreset", 5'd0, 5'd0, 1'b0, 8'd0);
        rst_a = 1'b0;
        step(G, R, 4'd9, 3'd0, 1'b0);
        chk_all("post_reset1", 5'd0, 5'd0, 1'b0, 8'd0);
        step(G, R, 4'd8, 3'd0, 1'b0);
        chk_all("post_reset2", 5'd0, 5'd0, 1'b0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
